// File: rtl/fsqrt_iter.sv
// ---------------------------------------------------------------------------
// fsqrt_iter -- iterative IEEE-754 single-precision square root.
//
// Computes y = sqrt(x) with round-to-nearest-even. Only one operation is in
// flight at a time. The root is resolved BITS_PER_CYCLE bits per clock with a
// non-restoring digit recurrence. Special operands (zero, denormal, negative,
// inf, NaN) take the same number of cycles as normal operands.
//
// Ports:
//   clk        in   1   clock; all state updates on the rising edge
//   rst        in   1   synchronous active-high reset
//   x          in  32   operand, sampled only on accept
//   in_valid   in   1   operand valid
//   in_ready   out  1   high only in IDLE
//   y          out 32   result, valid while out_valid=1
//   exception  out  1   exception flag paired with y
//   out_valid  out  1   result valid (DONE state)
//   out_ready  in   1   consumer takes the result (only looked at in DONE)
//   dbg_state  out  2   current FSM state (IDLE=0, CALC=1, ROUND=2, DONE=3)
//
// Handshake: an operand is accepted at a rising edge where in_valid and
// in_ready are both 1; a result is consumed at a rising edge where out_valid
// and out_ready are both 1. Neither valid may depend combinationally on the
// matching ready.
//
// Timing: counting the accepting edge as edge 1, out_valid rises after edge
// N+2 (N = 25/BITS_PER_CYCLE): N CALC cycles, one ROUND cycle, then DONE.
// ---------------------------------------------------------------------------
module fsqrt_iter #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        exception,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  dbg_state
);

  // Only step sizes that divide the 25 root bits evenly are supported.
  generate
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 5 || BITS_PER_CYCLE == 25)) begin : g_bad_k
      $error("fsqrt_iter: BITS_PER_CYCLE must be 1, 5 or 25");
    end
  endgenerate

  localparam int N  = 25 / BITS_PER_CYCLE;
  // Partial remainder width: the remainder stays below 2*Q+1 < 2^26, and one
  // step shifts it by two bits plus an add of up to 2^27, so 29 bits with
  // the MSB as sign is enough.
  localparam int RW = 29;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [49:0]    d_q, d_d;        // radicand, consumed two bits per root bit
  logic [24:0]    q_q, q_d;        // root bits resolved so far
  logic [RW-1:0]  r_q, r_d;        // signed partial remainder
  logic [7:0]     exp_q, exp_d;    // result exponent before rounding carry
  logic           spec_q, spec_d;  // operand is a special case
  logic [31:0]    spec_y_q, spec_y_d;
  logic           spec_exc_q, spec_exc_d;
  logic [31:0]    y_q, y_d;
  logic           exc_q, exc_d;

  // -------------------------------------------------------------------------
  // Operand classification and unpacking
  // -------------------------------------------------------------------------
  logic        x_sign;
  logic [7:0]  x_exp;
  logic [22:0] x_man;
  logic        cls_spec;
  logic [31:0] cls_y;
  logic        cls_exc;
  logic [24:0] sig_adj;
  logic [7:0]  exp_in;

  assign x_sign = x[31];
  assign x_exp  = x[30:23];
  assign x_man  = x[22:0];

  always_comb begin
    cls_spec = 1'b1;
    cls_y    = 32'h0000_0000;
    cls_exc  = x_sign | (x_exp == 8'hFF);
    if (x_exp == 8'hFF) begin
      // NaN and -inf give the quiet NaN; +inf passes through.
      cls_y = ((x_man != 23'd0) || x_sign) ? 32'h7FC0_0000 : 32'h7F80_0000;
    end else if (x_exp == 8'h00) begin
      // Denormals are flushed, so they behave exactly like a signed zero.
      cls_y = x_sign ? 32'h8000_0000 : 32'h0000_0000;
    end else if (x_sign) begin
      cls_y = 32'h7FC0_0000;
    end else begin
      cls_spec = 1'b0;
    end
  end

  // Unbiased exponent e = E-127 is odd exactly when E is even; in that case
  // the significand is doubled so the halved exponent stays an integer.
  assign sig_adj = x_exp[0] ? {1'b0, 1'b1, x_man} : {1'b1, x_man, 1'b0};

  // floor((E-127)/2) + 127 == floor((E+127)/2), which needs no signed math.
  assign exp_in = 8'((9'({1'b0, x_exp}) + 9'd127) >> 1);

  // -------------------------------------------------------------------------
  // Non-restoring square-root recurrence, BITS_PER_CYCLE steps per clock.
  // Radicand D = sig_adj * 2^25, so the 25-bit integer root carries the
  // leading 1, 23 fraction bits and the round bit.
  // -------------------------------------------------------------------------
  logic [49:0]   d_w;
  logic [24:0]   q_w;
  logic [RW-1:0] r_w;
  logic [1:0]    pair;

  always_comb begin
    d_w  = d_q;
    q_w  = q_q;
    r_w  = r_q;
    pair = 2'b00;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      pair = d_w[49:48];
      d_w  = {d_w[47:0], 2'b00};
      // Non-negative remainder: try subtracting 4Q+1; negative remainder:
      // restore lazily by adding 4Q+3 on the next step instead.
      if (!r_w[RW-1]) begin
        r_w = {r_w[RW-3:0], pair} - {2'b00, q_w, 2'b01};
      end else begin
        r_w = {r_w[RW-3:0], pair} + {2'b00, q_w, 2'b11};
      end
      q_w = {q_w[23:0], ~r_w[RW-1]};
    end
  end

  // -------------------------------------------------------------------------
  // Rounding: q_q[0] is the round bit, the fixed-up remainder gives sticky.
  // -------------------------------------------------------------------------
  logic [RW-1:0] r_fix;
  logic          sticky;
  logic          round_up;
  logic [23:0]   frac_sum;
  logic [7:0]    exp_r;
  logic [31:0]   y_norm;

  always_comb begin
    // A negative final remainder is short by exactly 2Q+1.
    r_fix    = r_q[RW-1] ? (r_q + {3'b000, q_q, 1'b1}) : r_q;
    sticky   = (r_fix != '0);
    round_up = q_q[0] & (sticky | q_q[1]);
    // frac_sum[23] is the carry out of the fraction; it bumps the exponent
    // and leaves the fraction at zero.
    frac_sum = {1'b0, q_q[23:1]} + {23'd0, round_up};
    exp_r    = exp_q + {7'd0, frac_sum[23]};
    y_norm   = {1'b0, exp_r, frac_sum[22:0]};
  end

  // -------------------------------------------------------------------------
  // FSM: next state and datapath loads
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d_d        = d_q;
    q_d        = q_q;
    r_d        = r_q;
    exp_d      = exp_q;
    spec_d     = spec_q;
    spec_y_d   = spec_y_q;
    spec_exc_d = spec_exc_q;
    y_d        = y_q;
    exc_d      = exc_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = CALC;
          cnt_d      = 5'(N - 1);
          d_d        = {sig_adj, 25'd0};
          q_d        = '0;
          r_d        = '0;
          exp_d      = exp_in;
          spec_d     = cls_spec;
          spec_y_d   = cls_y;
          spec_exc_d = cls_exc;
        end
      end
      CALC: begin
        d_d = d_w;
        q_d = q_w;
        r_d = r_w;
        if (cnt_q == 5'd0) begin
          state_d = ROUND;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ROUND: begin
        y_d     = spec_q ? spec_y_q : y_norm;
        exc_d   = spec_q ? spec_exc_q : 1'b0;
        state_d = DONE;
      end
      DONE: begin
        // No accept here: the next operand waits for IDLE.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      d_q        <= '0;
      q_q        <= '0;
      r_q        <= '0;
      exp_q      <= '0;
      spec_q     <= 1'b0;
      spec_y_q   <= '0;
      spec_exc_q <= 1'b0;
      y_q        <= '0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_q        <= d_d;
      q_q        <= q_d;
      r_q        <= r_d;
      exp_q      <= exp_d;
      spec_q     <= spec_d;
      spec_y_q   <= spec_y_d;
      spec_exc_q <= spec_exc_d;
      y_q        <= y_d;
      exc_q      <= exc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign exception = exc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fsqrt_iter.sv
// ---------------------------------------------------------------------------
// tb_fsqrt_iter -- bench for fsqrt_iter with BITS_PER_CYCLE = 1, 5 and 25.
// Three instances share clk/rst and are exercised one at a time.
// ---------------------------------------------------------------------------
module tb_fsqrt_iter;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] x_s         [3];
  logic        in_valid_s  [3];
  logic        in_ready_s  [3];
  logic [31:0] y_s         [3];
  logic        exc_s       [3];
  logic        out_valid_s [3];
  logic        out_ready_s [3];
  logic [1:0]  st_s        [3];

  int kv [3] = '{1, 5, 25};

  fsqrt_iter #(.BITS_PER_CYCLE(1)) u_k1 (
    .clk(clk), .rst(rst), .x(x_s[0]), .in_valid(in_valid_s[0]),
    .in_ready(in_ready_s[0]), .y(y_s[0]), .exception(exc_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .dbg_state(st_s[0]));

  fsqrt_iter #(.BITS_PER_CYCLE(5)) u_k5 (
    .clk(clk), .rst(rst), .x(x_s[1]), .in_valid(in_valid_s[1]),
    .in_ready(in_ready_s[1]), .y(y_s[1]), .exception(exc_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .dbg_state(st_s[1]));

  fsqrt_iter #(.BITS_PER_CYCLE(25)) u_k25 (
    .clk(clk), .rst(rst), .x(x_s[2]), .in_valid(in_valid_s[2]),
    .in_ready(in_ready_s[2]), .y(y_s[2]), .exception(exc_s[2]),
    .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .dbg_state(st_s[2]));

  // ---------------------------------------------------------------- scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_q [$];   // {exception, y}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, expv);
    end
  endtask

  // Reference: integer square root by bit search on the definition, then RNE.
  function automatic logic [32:0] ref_sqrt(input logic [31:0] xv);
    logic        s;
    int          e_b, e, odd, ex;
    longint      m, sig, rad, q, t, rem, keep;
    logic [31:0] yv;
    logic        ev;
    s   = xv[31];
    e_b = int'(xv[30:23]);
    m   = longint'(xv[22:0]);
    if (e_b == 255) begin
      yv = ((m != 0) || s) ? 32'h7FC0_0000 : 32'h7F80_0000;
      ev = 1'b1;
    end else if (e_b == 0) begin
      yv = s ? 32'h8000_0000 : 32'h0000_0000;
      ev = s;
    end else if (s) begin
      yv = 32'h7FC0_0000;
      ev = 1'b1;
    end else begin
      e   = e_b - 127;
      odd = e & 1;
      sig = (64'd1 << 23) | m;
      rad = (odd != 0) ? (sig << 26) : (sig << 25);
      q   = 0;
      for (int b = 25; b >= 0; b--) begin
        t = q | (64'd1 << b);
        if (t * t <= rad) q = t;
      end
      rem  = rad - q * q;
      keep = q >> 1;
      if ((q & 1) != 0 && (rem != 0 || (keep & 1) != 0)) keep = keep + 1;
      ex = (e - odd) / 2 + 127;
      if (keep >= (64'd1 << 24)) begin
        keep = keep >> 1;
        ex   = ex + 1;
      end
      yv = {1'b0, 8'(ex), 23'(keep)};
      ev = 1'b0;
    end
    return {ev, yv};
  endfunction

  // ---------------------------------------------------------------- driver tasks
  // One full transaction on instance idx: accept, count edges to out_valid
  // (accepting edge counts as 1), compare, then release with out_ready.
  task automatic run_op(input int idx, input logic [31:0] xv, input logic [32:0] expd,
                        input string tag);
    int          lat;
    bit          got;
    logic [32:0] e;
    exp_q.push_back(expd);
    for (int c = 0; c < 50 && !in_ready_s[idx]; c++) begin
      @(posedge clk); #1;
    end
    x_s[idx]        = xv;
    in_valid_s[idx] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[idx] = 1'b0;
    x_s[idx]        = $urandom;   // must not disturb the in-flight op
    lat = 1;
    got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (out_valid_s[idx]) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    e = exp_q.pop_front();
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: out_valid never rose, want after %0d edges", tag, 25 / kv[idx] + 2);
    end else begin
      check({tag, " y"}, y_s[idx], e[31:0]);
      check({tag, " exc"}, 32'(exc_s[idx]), 32'(e[32]));
      check({tag, " latency"}, 32'(lat), 32'(25 / kv[idx] + 2));
    end
    out_ready_s[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[idx] = 1'b0;
    check({tag, " release in_ready"}, 32'(in_ready_s[idx]), 32'd1);
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        exc;
  } vec_t;

  vec_t vecs [13];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] xv;
    vecs[0]  = '{32'h4080_0000, 32'h4000_0000, 1'b0};
    vecs[1]  = '{32'h4000_0000, 32'h3FB5_04F3, 1'b0};
    vecs[2]  = '{32'h7F7F_FFFF, 32'h5F7F_FFFF, 1'b0};
    vecs[3]  = '{32'h0080_0000, 32'h2000_0000, 1'b0};
    vecs[4]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b0};
    vecs[5]  = '{32'hBF80_0000, 32'h7FC0_0000, 1'b1};
    vecs[6]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b1};
    vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b1};
    vecs[8]  = '{32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[9]  = '{32'h4110_0000, 32'h4040_0000, 1'b0};
    vecs[10] = '{32'h7FC0_0000, 32'h7FC0_0000, 1'b1};
    vecs[11] = '{32'hFF80_0000, 32'h7FC0_0000, 1'b1};
    vecs[12] = '{32'h8000_0001, 32'h8000_0000, 1'b1};

    for (int i = 0; i < 3; i++) begin
      x_s[i] = '0; in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b0;
    end

    // Reset with handshake inputs active: reset must win.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid_s[i] = 1'b1; out_ready_s[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset k%0d in_ready", kv[i]), 32'(in_ready_s[i]), 32'd1);
      check($sformatf("reset k%0d out_valid", kv[i]), 32'(out_valid_s[i]), 32'd0);
      check($sformatf("reset k%0d y", kv[i]), y_s[i], 32'd0);
      check($sformatf("reset k%0d exc", kv[i]), 32'(exc_s[i]), 32'd0);
      in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b0;
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table on every step size.
    for (int i = 0; i < 3; i++)
      for (int v = 0; v < 13; v++)
        run_op(i, vecs[v].x, {vecs[v].exc, vecs[v].y},
               $sformatf("vec%0d k%0d x=%08h", v, kv[i], vecs[v].x));

    // Random sweep against the reference; mostly positive normals of both
    // exponent parities, with some fully random patterns for the specials.
    for (int i = 0; i < 3; i++)
      for (int n = 0; n < 300; n++) begin
        if ($urandom_range(0, 9) == 0) xv = $urandom;
        else xv = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
        run_op(i, xv, ref_sqrt(xv), $sformatf("rand k%0d x=%08h", kv[i], xv));
      end

    // Backpressure on K=1: result held for 10 cycles, new operand ignored.
    x_s[0] = 32'h4080_0000; in_valid_s[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    for (int c = 0; c < 60 && !out_valid_s[0]; c++) begin
      @(posedge clk); #1;
    end
    check("bp out_valid", 32'(out_valid_s[0]), 32'd1);
    x_s[0] = 32'h4110_0000; in_valid_s[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d y", c), y_s[0], 32'h4000_0000);
      check($sformatf("bp hold%0d exc", c), 32'(exc_s[0]), 32'd0);
      check($sformatf("bp hold%0d out_valid", c), 32'(out_valid_s[0]), 32'd1);
      check($sformatf("bp hold%0d in_ready", c), 32'(in_ready_s[0]), 32'd0);
    end
    // out_ready with in_valid high: goes to IDLE, does not accept in DONE.
    out_ready_s[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0; out_ready_s[0] = 1'b0;
    check("bp release state", 32'(st_s[0]), 32'd0);
    check("bp release out_valid", 32'(out_valid_s[0]), 32'd0);
    check("bp release in_ready", 32'(in_ready_s[0]), 32'd1);

    // Reset in CALC cycle 5 on K=1, with out_ready high in the same cycle.
    x_s[0] = 32'h4080_0000; in_valid_s[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst in CALC", 32'(st_s[0]), 32'd1);
    rst = 1'b1; out_ready_s[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready_s[0] = 1'b0;
    check("midrst out_valid", 32'(out_valid_s[0]), 32'd0);
    check("midrst in_ready", 32'(in_ready_s[0]), 32'd1);
    check("midrst y", y_s[0], 32'd0);
    run_op(0, 32'h4110_0000, {1'b0, 32'h4040_0000}, "after midrst 9.0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
